alu_regfile_exec: RTL



---
 rtl/alu_regfile_exec_pkg.sv | 25 ++
 rtl/alu_regfile_exec_alu_core.sv | 59 +++++
 rtl/alu_regfile_exec.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_regfile_exec_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU execution unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_WB    = 2'd3;

endpackage

// File: rtl/alu_regfile_exec_alu_core.sv
// Combinational WIDTH-bit ALU: eight operations producing a result and {N,Z,C,V}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic [3:0]       o_nzcv
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_v;

  // Signed overflow of a + b_eff: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    w_sub   = (i_op == OP_SUB) || (i_op == OP_CMP);
    w_b_eff = w_sub ? ~i_b : i_b;
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    o_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_CMP: begin
        o_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = add_ovf(i_a, w_b_eff, w_sum[WIDTH-1:0]);
      end
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_SHL: begin
        o_res = {i_a[WIDTH-2:0], 1'b0};
        w_c   = i_a[WIDTH-1];
      end
      default: begin
        o_res = {1'b0, i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
    endcase
    o_nzcv         = '0;
    o_nzcv[FLAG_N] = o_res[WIDTH-1];
    o_nzcv[FLAG_Z] = (o_res == '0);
    o_nzcv[FLAG_C] = w_c;
    o_nzcv[FLAG_V] = w_v;
  end

endmodule

// File: rtl/alu_regfile_exec.sv
// Register file plus IDLE/FETCH/EXEC/WB sequencer around alu_core.
// Host writes land every cycle; a writeback on the same edge overrides them.
module alu_regfile_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_regs [NREGS];
  state_t           r_state;
  logic             r_done;

  logic [2:0]       r_op_p0;
  logic [AW-1:0]    r_src_a_p0;
  logic [AW-1:0]    r_src_b_p0;
  logic [AW-1:0]    r_dst_p0;

  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;

  logic [WIDTH-1:0] r_result_p2;
  logic [3:0]       r_flags_p2;

  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_nzcv;
  logic             w_wb_en;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a    (r_a_p1),
    .i_b    (r_b_p1),
    .i_op   (r_op_p0),
    .o_res  (w_res),
    .o_nzcv (w_nzcv)
  );

  // Sequencer and architectural outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_result_p2 <= '0;
      r_flags_p2  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_result_p2 <= w_res;
          r_flags_p2  <= w_nzcv;
          r_state     <= ST_WB;
        end
        default: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage p0: command capture in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      r_op_p0    <= op;
      r_src_a_p0 <= src_a;
      r_src_b_p0 <= src_b;
      r_dst_p0   <= dst;
    end
  end

  // Stage p1: operand fetch; a host write on this same edge is not yet visible.
  always_ff @(posedge clk) begin
    if (r_state == ST_FETCH) begin
      r_a_p1 <= r_regs[r_src_a_p0];
      r_b_p1 <= r_regs[r_src_b_p0];
    end
  end

  assign w_wb_en = (r_state == ST_WB) && (r_op_p0 != OP_CMP);

  // Register file: the writeback is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (wr_en) r_regs[wr_addr] <= wr_data;
      if (w_wb_en) r_regs[r_dst_p0] <= r_result_p2;
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign result  = r_result_p2;
  assign flags   = r_flags_p2;
  assign rd_data = r_regs[rd_addr];

endmodule
